// File: rtl/pong_pkg.sv
// Shared definitions for the pong game core: default geometry,
// keypad codes, FSM state encoding and winner codes.
package pong_pkg;

    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_BALL_SZ      = 8;
    localparam int DEF_P1_X         = 16;
    localparam int DEF_P2_X         = 616;
    localparam int DEF_PADDLE_STEP  = 4;
    localparam int DEF_BALL_STEP    = 2;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_WIN_SCORE    = 9;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_UP   = 4'h2;
    localparam logic [3:0] KEY_DOWN = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MOVE_NONE = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } move_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Only the two direction keys move a paddle; every other code is ignored.
    function automatic move_t decode_key(input logic [3:0] key);
        case (key)
            KEY_UP:   return MOVE_UP;
            KEY_DOWN: return MOVE_DOWN;
            default:  return MOVE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// Paddle step logic: decodes a keypad code and produces the next paddle
// top row, saturating at the top and bottom of the screen.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
    input  logic [3:0] keycode,
    input  logic [9:0] y_cur,
    output logic [9:0] y_next
);

    localparam logic [10:0] MAX_Y = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] STEP  = 11'(PADDLE_STEP);

    logic [10:0] y_ext;

    assign y_ext = {1'b0, y_cur};

    // Move one step in the requested direction, clamping instead of wrapping.
    always_comb begin
        y_next = y_cur;
        case (decode_key(keycode))
            MOVE_UP:   y_next = (y_ext > STEP) ? 10'(y_ext - STEP) : 10'd0;
            MOVE_DOWN: y_next = ((y_ext + STEP) < MAX_Y) ? 10'(y_ext + STEP) : MAX_Y[9:0];
            default:   y_next = y_cur;
        endcase
    end

endmodule

// File: rtl/pong_game_core.sv
// Pong game core: game FSM, ball physics, paddle positions and scoring,
// all advanced once per frame_tick and presented as registered outputs.
module pong_game_core
    import pong_pkg::*;
#(
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int BALL_SZ      = DEF_BALL_SZ,
    parameter int P1_X         = DEF_P1_X,
    parameter int P2_X         = DEF_P2_X,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int BALL_STEP    = DEF_BALL_STEP,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] keys_1,
    input  logic [3:0] keys_2,
    input  logic       start,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state,
    output logic [1:0] winner
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic [9:0] PADDLE_RST = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] BALL_X_RST = 10'(SCREEN_W / 2 - BALL_SZ / 2);
    localparam logic [9:0] BALL_Y_RST = 10'(SCREEN_H / 2 - BALL_SZ / 2);

    localparam logic signed [11:0] S_ZERO    = 12'sd0;
    localparam logic signed [11:0] S_STEP    = 12'(BALL_STEP);
    localparam logic signed [11:0] S_Y_HI    = 12'(SCREEN_H - BALL_SZ);
    localparam logic signed [11:0] S_X_HI    = 12'(SCREEN_W - BALL_SZ);
    localparam logic signed [11:0] S_P1_FACE = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] S_P2_FACE = 12'(P2_X - BALL_SZ);

    localparam logic [10:0] P1_BACK    = 11'(P1_X);
    localparam logic [10:0] P2_BACK    = 11'(P2_X + PADDLE_W - BALL_SZ);
    localparam logic [10:0] BALL_SZ_U  = 11'(BALL_SZ);
    localparam logic [10:0] PADDLE_H_U = 11'(PADDLE_H);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

    state_t cur_state;
    state_t next_state;

    logic             dx_neg;
    logic             dy_neg;
    logic [CNT_W-1:0] serve_cnt;
    logic [9:0]       paddle1_next;
    logic [9:0]       paddle2_next;

    logic start_game;
    logic serve_done;
    logic game_decided;

    logic signed [11:0] bx_s;
    logic signed [11:0] by_s;
    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic               overlap1;
    logic               overlap2;
    logic               hit1;
    logic               hit2;
    logic [9:0]         ball_x_play;
    logic [9:0]         ball_y_play;
    logic               dx_neg_play;
    logic               dy_neg_play;
    logic               miss_left;
    logic               miss_right;

    assign state = cur_state;

    pong_paddle #(
        .SCREEN_H    (SCREEN_H),
        .PADDLE_H    (PADDLE_H),
        .PADDLE_STEP (PADDLE_STEP)
    ) u_paddle1 (
        .keycode (keys_1),
        .y_cur   (paddle1_y),
        .y_next  (paddle1_next)
    );

    pong_paddle #(
        .SCREEN_H    (SCREEN_H),
        .PADDLE_H    (PADDLE_H),
        .PADDLE_STEP (PADDLE_STEP)
    ) u_paddle2 (
        .keycode (keys_2),
        .y_cur   (paddle2_y),
        .y_next  (paddle2_next)
    );

    assign bx_s = $signed({2'b00, ball_x});
    assign by_s = $signed({2'b00, ball_y});

    assign overlap1 = (({1'b0, ball_y} + BALL_SZ_U) > {1'b0, paddle1_y}) &&
                      ({1'b0, ball_y} < ({1'b0, paddle1_y} + PADDLE_H_U));
    assign overlap2 = (({1'b0, ball_y} + BALL_SZ_U) > {1'b0, paddle2_y}) &&
                      ({1'b0, ball_y} < ({1'b0, paddle2_y} + PADDLE_H_U));

    // One frame of ball motion: wall bounce, paddle returns and misses resolved together.
    always_comb begin
        nx = dx_neg ? (bx_s - S_STEP) : (bx_s + S_STEP);
        ny = dy_neg ? (by_s - S_STEP) : (by_s + S_STEP);

        ball_y_play = ny[9:0];
        dy_neg_play = dy_neg;
        if (ny <= S_ZERO) begin
            ball_y_play = 10'd0;
            dy_neg_play = 1'b0;
        end else if (ny >= S_Y_HI) begin
            ball_y_play = S_Y_HI[9:0];
            dy_neg_play = 1'b1;
        end

        hit1 = dx_neg && (nx <= S_P1_FACE) && ({1'b0, ball_x} >= P1_BACK) && overlap1;
        hit2 = !dx_neg && (nx >= S_P2_FACE) && ({1'b0, ball_x} <= P2_BACK) && overlap2;

        ball_x_play = nx[9:0];
        dx_neg_play = dx_neg;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
        if (hit1) begin
            ball_x_play = S_P1_FACE[9:0];
            dx_neg_play = 1'b0;
        end else if (hit2) begin
            ball_x_play = S_P2_FACE[9:0];
            dx_neg_play = 1'b1;
        end else if (nx <= S_ZERO) begin
            ball_x_play = 10'd0;
            dx_neg_play = 1'b1;
            miss_left   = 1'b1;
        end else if (nx >= S_X_HI) begin
            ball_x_play = S_X_HI[9:0];
            dx_neg_play = 1'b0;
            miss_right  = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // FSM next-state logic; a start pulse outranks the frame tick.
    always_comb begin
        next_state = cur_state;
        if (start_game) begin
            next_state = ST_SERVE;
        end else if (frame_tick) begin
            case (cur_state)
                ST_SERVE: if (serve_done) next_state = ST_PLAY;
                ST_PLAY:  if (miss_left || miss_right) next_state = ST_POINT;
                ST_POINT: next_state = game_decided ? ST_GAMEOVER : ST_SERVE;
                default:  next_state = cur_state;
            endcase
        end
    end

    // FSM control outputs steering the datapath.
    always_comb begin
        start_game   = start && ((cur_state == ST_IDLE) || (cur_state == ST_GAMEOVER));
        serve_done   = (serve_cnt == SERVE_LAST);
        game_decided = (score1 == WIN) || (score2 == WIN);
    end

    // Positions, directions, scores and serve counter advance once per frame.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            paddle1_y <= PADDLE_RST;
            paddle2_y <= PADDLE_RST;
            ball_x    <= BALL_X_RST;
            ball_y    <= BALL_Y_RST;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= WIN_NONE;
            serve_cnt <= '0;
        end else if (start_game) begin
            ball_x    <= BALL_X_RST;
            ball_y    <= BALL_Y_RST;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= WIN_NONE;
            serve_cnt <= '0;
        end else if (frame_tick) begin
            case (cur_state)
                ST_SERVE: begin
                    paddle1_y <= paddle1_next;
                    paddle2_y <= paddle2_next;
                    serve_cnt <= serve_done ? '0 : serve_cnt + 1'b1;
                end
                ST_PLAY: begin
                    paddle1_y <= paddle1_next;
                    paddle2_y <= paddle2_next;
                    ball_x    <= ball_x_play;
                    ball_y    <= ball_y_play;
                    dx_neg    <= dx_neg_play;
                    dy_neg    <= dy_neg_play;
                    if (miss_left && (score2 != WIN)) score2 <= score2 + 4'd1;
                    if (miss_right && (score1 != WIN)) score1 <= score1 + 4'd1;
                end
                ST_POINT: begin
                    if (game_decided) begin
                        winner <= (score1 == WIN) ? WIN_P1 : WIN_P2;
                    end else begin
                        ball_x    <= BALL_X_RST;
                        ball_y    <= BALL_Y_RST;
                        dy_neg    <= 1'b0;
                        serve_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_core.sv
// Self-checking bench for pong_game_core: a frame-level game model runs
// alongside the DUT and is compared every cycle, with directed rallies
// whose outcomes are worked out by hand and a randomized play phase.
module tb_pong_game_core;
    import pong_pkg::*;

    localparam int H        = 480;
    localparam int W        = 640;
    localparam int PH       = 64;
    localparam int BSZ      = 8;
    localparam int P1X      = 16;
    localparam int P2X      = 616;
    localparam int PW       = 8;
    localparam int SERVES   = 60;
    localparam int WINS     = 9;

    logic       CLOCK_50;
    logic       rst;
    logic       frame_tick;
    logic [3:0] keys_1;
    logic [3:0] keys_2;
    logic       start;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] state;
    logic [1:0] winner;

    int vector_count = 0;
    int miss_count   = 0;
    bit check_enable = 1'b0;

    state_t m_state;
    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_win, m_cnt;
    int p1o, p2o, nx, ny;

    pong_game_core dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .frame_tick (frame_tick),
        .keys_1     (keys_1),
        .keys_2     (keys_2),
        .start      (start),
        .paddle1_y  (paddle1_y),
        .paddle2_y  (paddle2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score1     (score1),
        .score2     (score2),
        .state      (state),
        .winner     (winner)
    );

    // 50 MHz clock.
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vector_count++;
        if (actual != expected) begin
            miss_count++;
            $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic tick, input logic [3:0] k1, input logic [3:0] k2,
                                 input logic st, input logic rs);
        frame_tick = tick;
        keys_1     = k1;
        keys_2     = k2;
        start      = st;
        rst        = rs;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic runTicks(input int n, input logic [3:0] k1, input logic [3:0] k2);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, k1, k2, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"},  int'(state), int'(ST_IDLE));
        checkOutput({tag, "_p1"},     int'(paddle1_y), 208);
        checkOutput({tag, "_p2"},     int'(paddle2_y), 208);
        checkOutput({tag, "_bx"},     int'(ball_x), 316);
        checkOutput({tag, "_by"},     int'(ball_y), 236);
        checkOutput({tag, "_s1"},     int'(score1), 0);
        checkOutput({tag, "_s2"},     int'(score2), 0);
        checkOutput({tag, "_winner"}, int'(winner), 0);
    endtask

    function automatic int move_paddle(input int y, input logic [3:0] key);
        if (key == 4'h2) return (y - 4 < 0) ? 0 : y - 4;
        if (key == 4'h8) return (y + 4 > H - PH) ? H - PH : y + 4;
        return y;
    endfunction

    function automatic logic [3:0] random_key();
        logic [3:0] pool [8] = '{4'h0, 4'h2, 4'h8, 4'h2, 4'h8, 4'h5, 4'hF, 4'h0};
        return pool[$urandom_range(0, 7)];
    endfunction

    // Frame-level game model, advanced on the same edges the DUT samples.
    always @(posedge CLOCK_50) begin
        if (rst) begin
            m_state = ST_IDLE;
            m_p1 = (H - PH) / 2;  m_p2 = (H - PH) / 2;
            m_bx = W / 2 - BSZ / 2;  m_by = H / 2 - BSZ / 2;
            m_dx = 2;  m_dy = 2;
            m_s1 = 0;  m_s2 = 0;  m_win = 0;  m_cnt = 0;
        end else if (start && (m_state == ST_IDLE || m_state == ST_GAMEOVER)) begin
            m_state = ST_SERVE;
            m_bx = W / 2 - BSZ / 2;  m_by = H / 2 - BSZ / 2;
            m_dx = 2;  m_dy = 2;
            m_s1 = 0;  m_s2 = 0;  m_win = 0;  m_cnt = 0;
        end else if (frame_tick) begin
            case (m_state)
                ST_SERVE: begin
                    m_p1 = move_paddle(m_p1, keys_1);
                    m_p2 = move_paddle(m_p2, keys_2);
                    m_cnt++;
                    if (m_cnt == SERVES) begin
                        m_state = ST_PLAY;
                        m_cnt = 0;
                    end
                end
                ST_PLAY: begin
                    p1o = m_p1;  p2o = m_p2;
                    m_p1 = move_paddle(m_p1, keys_1);
                    m_p2 = move_paddle(m_p2, keys_2);
                    nx = m_bx + m_dx;
                    ny = m_by + m_dy;
                    if (ny <= 0) begin
                        ny = 0;  m_dy = 2;
                    end else if (ny >= H - BSZ) begin
                        ny = H - BSZ;  m_dy = -2;
                    end
                    if (m_dx < 0 && nx <= P1X + PW && m_bx >= P1X && m_by + BSZ > p1o && m_by < p1o + PH) begin
                        nx = P1X + PW;  m_dx = 2;
                    end else if (m_dx > 0 && nx >= P2X - BSZ && m_bx + BSZ <= P2X + PW &&
                                 m_by + BSZ > p2o && m_by < p2o + PH) begin
                        nx = P2X - BSZ;  m_dx = -2;
                    end else if (nx <= 0) begin
                        nx = 0;  m_dx = -2;
                        m_s2 = (m_s2 < WINS) ? m_s2 + 1 : WINS;
                        m_state = ST_POINT;
                    end else if (nx >= W - BSZ) begin
                        nx = W - BSZ;  m_dx = 2;
                        m_s1 = (m_s1 < WINS) ? m_s1 + 1 : WINS;
                        m_state = ST_POINT;
                    end
                    m_bx = nx;  m_by = ny;
                end
                ST_POINT: begin
                    if (m_s1 == WINS) begin
                        m_state = ST_GAMEOVER;  m_win = 1;
                    end else if (m_s2 == WINS) begin
                        m_state = ST_GAMEOVER;  m_win = 2;
                    end else begin
                        m_state = ST_SERVE;
                        m_bx = W / 2 - BSZ / 2;  m_by = H / 2 - BSZ / 2;
                        m_dy = 2;  m_cnt = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge CLOCK_50) begin
        if (check_enable) begin
            checkOutput("m_state",  int'(state),     int'(m_state));
            checkOutput("m_p1",     int'(paddle1_y), m_p1);
            checkOutput("m_p2",     int'(paddle2_y), m_p2);
            checkOutput("m_bx",     int'(ball_x),    m_bx);
            checkOutput("m_by",     int'(ball_y),    m_by);
            checkOutput("m_s1",     int'(score1),    m_s1);
            checkOutput("m_s2",     int'(score2),    m_s2);
            checkOutput("m_winner", int'(winner),    m_win);
        end
    end

    initial begin
        logic [3:0] k1;
        bit         done;

        frame_tick = 1'b0;  keys_1 = 4'h0;  keys_2 = 4'h0;  start = 1'b0;  rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h2, 4'h8, 1'b1, 1'b1);
        check_enable = 1'b1;
        checkResetValues("reset");

        // Idle: ticks and keys must not move anything.
        runTicks(5, 4'h2, 4'h8);
        checkOutput("idle_p1", int'(paddle1_y), 208);

        // First serve: P1 holds up, P2 holds a non-movement code.
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("start_state", int'(state), int'(ST_SERVE));
        runTicks(SERVES, 4'h2, 4'h5);
        checkOutput("serve_play", int'(state), int'(ST_PLAY));
        checkOutput("serve_p1_sat", int'(paddle1_y), 0);
        checkOutput("serve_p2_hold", int'(paddle2_y), 208);
        checkOutput("serve_bx", int'(ball_x), 316);
        checkOutput("serve_by", int'(ball_y), 236);
        runTicks(1, 4'h0, 4'h0);
        checkOutput("play1_bx", int'(ball_x), 318);
        checkOutput("play1_by", int'(ball_y), 238);
        runTicks(117, 4'h0, 4'h0);
        checkOutput("floor_by", int'(ball_y), 472);
        runTicks(1, 4'h0, 4'h0);
        checkOutput("floor_back", int'(ball_y), 470);
        runTicks(39, 4'h0, 4'h0);
        checkOutput("p2miss_state", int'(state), int'(ST_POINT));
        checkOutput("p2miss_s1", int'(score1), 1);
        checkOutput("p2miss_bx", int'(ball_x), 632);
        checkOutput("p2miss_by", int'(ball_y), 392);
        runTicks(1, 4'h0, 4'h0);
        checkOutput("point_serve", int'(state), int'(ST_SERVE));
        checkOutput("recentre_bx", int'(ball_x), 316);

        // Second rally: P2 parks at the bottom, returns the ball, P1 at top misses.
        runTicks(SERVES, 4'h0, 4'h8);
        checkOutput("p2_sat", int'(paddle2_y), 416);
        runTicks(146, 4'h0, 4'h0);
        checkOutput("p2hit_bx", int'(ball_x), 608);
        checkOutput("p2hit_by", int'(ball_y), 416);
        runTicks(207, 4'h0, 4'h0);
        checkOutput("ceil_pre", int'(ball_y), 2);
        runTicks(1, 4'h0, 4'h0);
        checkOutput("ceil_by", int'(ball_y), 0);
        runTicks(1, 4'h0, 4'h0);
        checkOutput("ceil_back", int'(ball_y), 2);
        runTicks(95, 4'h0, 4'h0);
        checkOutput("p1miss_state", int'(state), int'(ST_POINT));
        checkOutput("p1miss_s2", int'(score2), 1);
        checkOutput("p1miss_bx", int'(ball_x), 0);
        runTicks(1, 4'h0, 4'h0);
        runTicks(SERVES + 1, 4'h0, 4'h0);
        checkOutput("serve_p1_bx", int'(ball_x), 314);
        checkOutput("serve_p1_by", int'(ball_y), 238);

        // Randomized play, including stray starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), random_key(), random_key(),
                          ($urandom_range(0, 39) == 0), ($urandom_range(0, 799) == 0));
        end

        // Full game: P1 tracks the ball, P2 stays at the top until P1 wins.
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        checkResetValues("rst2");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        done = 1'b0;
        for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
            if (m_by + BSZ / 2 < m_p1 + PH / 2)      k1 = 4'h2;
            else if (m_by + BSZ / 2 > m_p1 + PH / 2) k1 = 4'h8;
            else                                     k1 = 4'h0;
            applyStimulus(1'b1, k1, 4'h2, 1'b0, 1'b0);
            done = (m_state == ST_GAMEOVER);
        end
        if (!done) begin
            checkOutput("gameover_timeout", 0, 1);
        end else begin
            checkOutput("go_state", int'(state), int'(ST_GAMEOVER));
            checkOutput("go_winner", int'(winner), 1);
            checkOutput("go_s1", int'(score1), 9);
            runTicks(5, 4'h2, 4'h8);
            applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
            checkOutput("restart_state", int'(state), int'(ST_SERVE));
            checkOutput("restart_s1", int'(score1), 0);
            checkOutput("restart_winner", int'(winner), 0);
        end

        // Reset mid-rally with tick and start also high.
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        runTicks(SERVES + 10, 4'h2, 4'h8);
        checkOutput("pre_rst_state", int'(state), int'(ST_PLAY));
        applyStimulus(1'b1, 4'h2, 4'h8, 1'b1, 1'b1);
        checkResetValues("midplay_rst");
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/pong_game_core.md
PONG_GAME_CORE -- requirements
Module: pong_game_core

Interface
REQ-001 SHALL have parameter SCREEN_H, default 480, visible rows.
REQ-002 SHALL have parameter SCREEN_W, default 640, visible columns.
REQ-003 SHALL have parameter PADDLE_H, default 64, paddle height in pixels.
REQ-004 SHALL have parameter PADDLE_W, default 8, paddle width in pixels.
REQ-005 SHALL have parameter BALL_SZ, default 8, ball edge length in pixels.
REQ-006 SHALL have parameter P1_X, default 16, left paddle x; P2_X, default 616, right paddle x.
REQ-007 SHALL have parameter PADDLE_STEP, default 4, pixels per frame; BALL_STEP, default 2, pixels per axis per frame.
REQ-008 SHALL have parameter SERVE_FRAMES, default 60; WIN_SCORE, default 9.
REQ-009 SHALL have port CLOCK_50, in, 1, sole clock; one clock, all logic on its rising edge.
REQ-010 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-011 SHALL have port frame_tick, in, 1, one-cycle pulse per frame from the VGA timing stage.
REQ-012 SHALL have ports keys_1 / keys_2, in, 4 each, keycodes from player1/player2 keypad scanners.
REQ-013 SHALL have port start, in, 1, one-cycle start/restart pulse.
REQ-014 SHALL have ports paddle1_y / paddle2_y, out, 10 each, paddle top row.
REQ-015 SHALL have ports ball_x / ball_y, out, 10 each, ball top-left.
REQ-016 SHALL have ports score1 / score2, out, 4 each; state, out, 3; winner, out, 2 (0 none, 1 P1, 2 P2).

Function
REQ-017 SHALL decode keycode 4'h2 as up and 4'h8 as down; all other values, including 4'h0 (no key), SHALL mean no movement.
REQ-018 SHALL update positions, counters and scores only in the cycle after frame_tick; outputs are registered with 1-cycle latency from frame_tick.
REQ-019 SHALL implement FSM IDLE, SERVE, PLAY, POINT, GAMEOVER.
REQ-020 IDLE: hold reset positions; start -> SERVE with scores 0.
REQ-021 SERVE: centre ball at (SCREEN_W/2-BALL_SZ/2, SCREEN_H/2-BALL_SZ/2), count SERVE_FRAMES ticks, then -> PLAY.
REQ-022 SERVE: dx SHALL point toward the player who lost the last point; first serve after start SHALL go toward P2 (dx=+BALL_STEP), with dy=+BALL_STEP.
REQ-023 Paddles SHALL move only in SERVE and PLAY, by PADDLE_STEP per tick, saturating at 0 and SCREEN_H-PADDLE_H; no wrap-around.
REQ-024 PLAY, walls: if next y <= 0 or >= SCREEN_H-BALL_SZ, clamp y to that bound and negate dy in the same tick.
REQ-025 PLAY, P1 hit: when dx<0, next x <= P1_X+PADDLE_W, x >= P1_X, and rows overlap (ball_y+BALL_SZ > paddle1_y and ball_y < paddle1_y+PADDLE_H), clamp x to P1_X+PADDLE_W and set dx positive; P2 mirrors with clamp to P2_X-BALL_SZ.
REQ-026 Wall and paddle hits in the same tick SHALL both apply.
REQ-027 PLAY, miss: next x <= 0 SHALL increment score2; next x >= SCREEN_W-BALL_SZ SHALL increment score1; then -> POINT.
REQ-028 POINT: last one tick, then -> GAMEOVER if either score equals WIN_SCORE (set winner), else -> SERVE.
REQ-029 GAMEOVER: freeze all positions; start -> SERVE with scores and winner cleared.
REQ-030 start outside IDLE and GAMEOVER SHALL be ignored; start coincident with frame_tick SHALL take priority over the tick update.
REQ-031 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-032 rst SHALL force state=IDLE, paddles=(SCREEN_H-PADDLE_H)/2 (208), ball=(316,236), scores=0, winner=0, serve counter=0, direction toward P2, including mid-rally; rst SHALL dominate start and frame_tick.

Structure
REQ-033 Keycodes, state encoding, and default geometry constants SHALL live in shared package pong_pkg.
REQ-034 Paddle decode/saturate SHALL be sub-module pong_paddle, instantiated twice.

Verification
REQ-035 rst, start, 60 ticks -> state PLAY, ball moving +2/+2 from (316,236).
REQ-036 keys_1=4'h2 held 60 ticks from y=208 -> paddle1_y decrements 4 per tick, saturates at 0; keys_1=4'h5 -> no movement.
REQ-037 ball_y=2, dy=-2 at tick -> ball_y=0, dy=+2.
REQ-038 ball at x=26, dx=-2, paddle1_y overlapping -> x=24, dx=+2; paddle away -> ball reaches x=0, score2=1, POINT, then SERVE toward P1.
REQ-039 score1=8, P2 miss -> score1=9, GAMEOVER, winner=1; start -> SERVE, scores 0.
REQ-040 rst asserted mid-PLAY with frame_tick high -> next cycle all outputs equal their reset values.
